// File: rtl/featuremap_accum_if.sv
// Pixel stream bundle for featuremap_accum: channel-vector input side and
// activated-pixel output side, each with a valid/ready handshake.
interface featuremap_accum_if #(
   parameter int CHANNELS   = 32,
   parameter int DATA_WIDTH = 16
);
   logic [CHANNELS*DATA_WIDTH-1:0] data_in;
   logic                           valid_in;
   logic                           ready_in;
   logic [DATA_WIDTH-1:0]          data_out;
   logic                           valid_out;
   logic                           ready_out;
   logic                           last_out;
   logic                           sat_out;

   modport slave (
      input  data_in, valid_in, ready_out,
      output ready_in, data_out, valid_out, last_out, sat_out
   );

   modport master (
      output data_in, valid_in, ready_out,
      input  ready_in, data_out, valid_out, last_out, sat_out
   );
endinterface

// File: rtl/featuremap_accum.sv
// Per-pixel channel reduction: pipelined adder tree, bias, optional leaky-ReLU,
// saturation to DATA_WIDTH, with frame-position tagging of the last pixel.
module featuremap_accum #(
   parameter int CHANNELS    = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int IMG_SIZE    = 104,
   parameter int BIAS        = 0,
   parameter int LEAKY       = 1,
   parameter int LEAKY_SHIFT = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   featuremap_accum_if.slave  bus
);
   localparam int LVLS      = $clog2(CHANNELS);
   localparam int L         = LVLS + 1;
   localparam int ACC_WIDTH = DATA_WIDTH + LVLS + 1;
   localparam int CW        = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
   localparam logic signed [DATA_WIDTH-1:0] BIAS_D = DATA_WIDTH'(BIAS);

   logic          adv, accept, is_last;
   logic [L:1]    vld_q, last_q;
   logic [CW-1:0] col_q, col_d, row_q, row_d;

   // A full output slot that downstream refuses freezes the whole pipe.
   assign adv         = !(vld_q[L] && !bus.ready_out);
   assign accept      = bus.valid_in && adv;
   assign is_last     = (col_q == CW'(IMG_SIZE-1)) && (row_q == CW'(IMG_SIZE-1));
   assign bus.ready_in = adv;

   for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
      localparam int W = DATA_WIDTH + l;
      localparam int N = CHANNELS >> l;
      logic [N-1:0][W-1:0] node;
      if (l == 0) begin : g_in
         assign node = bus.data_in;
      end else begin : g_add
         logic [N-1:0][W-1:0] node_q;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               node_q <= '0;
            end else if (adv) begin
               for (int n = 0; n < N; n++)
                  node_q[n] <= {g_lvl[l-1].node[2*n][W-2],   g_lvl[l-1].node[2*n]} +
                               {g_lvl[l-1].node[2*n+1][W-2], g_lvl[l-1].node[2*n+1]};
            end
         end
         assign node = node_q;
      end
   end

   logic signed [ACC_WIDTH-1:0] sum_s, biased_s, act_s;
   logic [ACC_WIDTH-DATA_WIDTH:0] hi;
   logic [DATA_WIDTH-1:0]       res_d, data_q;
   logic                        sat_d, sat_q;

   always_comb begin
      sum_s    = ACC_WIDTH'($signed(g_lvl[LVLS].node[0]));
      biased_s = sum_s + ACC_WIDTH'(BIAS_D);
      act_s    = (LEAKY != 0 && biased_s[ACC_WIDTH-1]) ? (biased_s >>> LEAKY_SHIFT) : biased_s;
      hi       = act_s[ACC_WIDTH-1:DATA_WIDTH-1];
      res_d    = act_s[DATA_WIDTH-1:0];
      sat_d    = 1'b0;
      // Value fits only if every bit above the target sign bit matches it.
      if (!((&hi) || !(|hi))) begin
         sat_d = 1'b1;
         res_d = act_s[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_q == CW'(IMG_SIZE-1)) begin
            col_d = '0;
            row_d = (row_q == CW'(IMG_SIZE-1)) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q  <= '0;
         last_q <= '0;
         data_q <= '0;
         sat_q  <= 1'b0;
         col_q  <= '0;
         row_q  <= '0;
      end else if (adv) begin
         vld_q  <= {vld_q[L-1:1], accept};
         last_q <= {last_q[L-1:1], accept && is_last};
         data_q <= res_d;
         sat_q  <= vld_q[L-1] && sat_d;
         col_q  <= col_d;
         row_q  <= row_d;
      end
   end

   assign bus.valid_out = vld_q[L];
   assign bus.last_out  = last_q[L];
   assign bus.data_out  = data_q;
   assign bus.sat_out   = sat_q;
endmodule

// File: doc/featuremap_accum.md
FEATUREMAP_ACCUM -- requirements
Module: featuremap_accum

Interface
REQ-001 Parameter CHANNELS, default 32, number of per-channel convolution results summed per pixel; power of two, 2..64.
REQ-002 Parameter DATA_WIDTH, default 16, signed two's-complement width of each channel value and of data_out.
REQ-003 Parameter IMG_SIZE, default 104, pixels per row and rows per frame.
REQ-004 Parameter BIAS, default 0, signed DATA_WIDTH bias added once per pixel.
REQ-005 Parameter LEAKY, default 1; 1 = leaky-ReLU enabled, 0 = linear.
REQ-006 Parameter LEAKY_SHIFT, default 3, negative-slope shift amount (slope 2^-LEAKY_SHIFT).
REQ-007 Clk  input  1  single clock; all state on rising edge.
REQ-008 Rst  input  1  asynchronous, active-high reset.
REQ-009 data_in  input  CHANNELS*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 valid_in  input  1  data_in holds one pixel.
REQ-011 ready_in  output  1  block accepts data_in this cycle.
REQ-012 data_out  output  DATA_WIDTH  activated, saturated pixel result.
REQ-013 valid_out  output  1  data_out valid.
REQ-014 ready_out  input  1  downstream accepts data_out.
REQ-015 last_out  output  1  qualifies valid_out; final pixel of frame.
REQ-016 sat_out  output  1  qualifies valid_out; result was clamped.

Function
REQ-017 Pipeline SHALL have L = log2(CHANNELS)+1 register stages: one per binary adder-tree level, then one bias/activation/saturation stage.
REQ-018 Pipeline SHALL advance only when adv = !(valid_out && !ready_out); when adv=0 every stage register, valid bit and counter SHALL hold.
REQ-019 ready_in SHALL equal adv combinationally; a pixel is accepted when valid_in && ready_in.
REQ-020 With ready_out held 1, a pixel accepted at cycle t SHALL appear with valid_out=1 at cycle t+L.
REQ-021 Stalled output (valid_out && !ready_out) SHALL keep data_out, last_out, sat_out stable.
REQ-022 Adder tree SHALL sign-extend inputs and grow one bit per level; final sum exact in ACC_WIDTH = DATA_WIDTH+log2(CHANNELS)+1 bits, no intermediate overflow.
REQ-023 Final stage SHALL compute s = sum + sign-extended BIAS.
REQ-024 If LEAKY=1 and s<0, s SHALL become s >>> LEAKY_SHIFT (arithmetic, rounds toward minus infinity); otherwise s unchanged.
REQ-025 Result SHALL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; sat_out=1 exactly when clamped.
REQ-026 Column counter (0..IMG_SIZE-1) SHALL increment on each accepted input, wrapping to 0 and incrementing row counter (0..IMG_SIZE-1), which wraps to 0 after IMG_SIZE-1.
REQ-027 A pixel accepted at col=row=IMG_SIZE-1 SHALL carry a last tag through the pipeline, emerging as last_out=1 with that pixel; last_out=0 otherwise.
REQ-028 Bubbles (valid_in=0 while ready_in=1) SHALL propagate as valid=0 without counter change.

Reset
REQ-029 Rst=1 SHALL immediately clear all stage valid bits, valid_out, last_out, sat_out, data_out (to 0) and both counters, independent of Clk.
REQ-030 Reset mid-frame SHALL discard all in-flight pixels; the first pixel accepted after release is col=0,row=0.
REQ-031 ready_in SHALL be 1 during and after reset (valid_out=0 forces adv=1).

Verification (CHANNELS=4, DATA_WIDTH=16, IMG_SIZE=4, LEAKY=1, LEAKY_SHIFT=3 unless noted)
REQ-032 Latency: channels {100,200,300,400}, BIAS=10, ready_out=1 -> data_out=1010, sat_out=0, valid_out exactly 3 cycles after acceptance.
REQ-033 Leaky/rounding: channels {-40,0,0,0}, BIAS=0 -> data_out=-5; channels {-1,0,0,0} -> data_out=-1; LEAKY=0 with {-40,0,0,0} -> -40.
REQ-034 Saturation: all channels 32767, BIAS=0 -> data_out=32767, sat_out=1; LEAKY=0, all -32768 -> data_out=-32768, sat_out=1.
REQ-035 Back-pressure: stream 16 pixels, ready_out toggled 0/1 pseudo-randomly -> outputs in order, none lost or duplicated, stalled data_out stable, ready_in=0 only while valid_out && !ready_out.
REQ-036 Frame tagging: 32 consecutive pixels with random bubbles -> last_out=1 exactly on output pixels 16 and 32.
REQ-037 Reset mid-operation: assert Rst asynchronously between edges with 2 pixels in flight -> valid_out=0 immediately; after release, next 16 pixels produce last_out only on pixel 16.
